// File: rtl/s_mem_init_engine.sv
// s_mem_init_engine: walks a memory once after start, either writing a
// pattern (identity, constant fill, descending) or reading it back and
// checking that every word holds its own address.
module s_mem_init_engine #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  write_enable_out,
    input  logic [DATA_WIDTH-1:0] read_data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  verify_error,
    output logic [ADDR_WIDTH-1:0] error_address
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // One extra index bit lets DEPTH == 2^ADDR_WIDTH finish without wrapping.
    localparam logic [ADDR_WIDTH:0] LAST_INDEX = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE_INDEX  = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH:0]   r_index;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_fill;
    logic                  r_verifyError;
    logic [ADDR_WIDTH-1:0] r_errorAddress;
    logic                  w_lastIndex;
    logic                  w_startAccept;
    logic                  w_cmpValid;
    logic [ADDR_WIDTH:0]   w_cmpIndex;

    assign w_lastIndex   = (r_index == LAST_INDEX);
    assign w_startAccept = start && !abort;
    assign verify_error  = r_verifyError;
    assign error_address = r_errorAddress;

    // State register; reset drops straight back to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode, memory-side outputs and read-back compare selection.
    always_comb begin
        w_nextState      = r_state;
        write_enable_out = 1'b0;
        address_out      = '0;
        data_out         = '0;
        busy             = (r_state != S_IDLE);
        done             = 1'b0;
        w_cmpValid       = 1'b0;
        w_cmpIndex       = LAST_INDEX;

        case (r_state)
            S_IDLE: begin
                if (w_startAccept) begin
                    w_nextState = (mode == 2'd3) ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_lastIndex) begin
                    w_nextState = S_DONE;
                end
                if (!abort) begin
                    write_enable_out = 1'b1;
                    address_out      = ADDR_WIDTH'(r_index);
                    case (r_mode)
                        2'd0:    data_out = DATA_WIDTH'(r_index);
                        2'd1:    data_out = r_fill;
                        2'd2:    data_out = DATA_WIDTH'(LAST_INDEX - r_index);
                        default: data_out = '0;
                    endcase
                end
            end
            S_READ: begin
                if (w_lastIndex) begin
                    w_nextState = S_DRAIN;
                end
                address_out = ADDR_WIDTH'(r_index);
                w_cmpValid  = (r_index != '0);
                w_cmpIndex  = r_index - ONE_INDEX;
            end
            S_DRAIN: begin
                w_nextState = S_DONE;
                w_cmpValid  = 1'b1;
                w_cmpIndex  = LAST_INDEX;
            end
            S_DONE: begin
                w_nextState = S_IDLE;
                done        = !abort;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        if (abort && (r_state != S_IDLE)) begin
            w_nextState = S_IDLE;
        end
    end

    // Index walk, start-time capture of mode/fill, and sticky first-mismatch record.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_index        <= '0;
            r_mode         <= '0;
            r_fill         <= '0;
            r_verifyError  <= 1'b0;
            r_errorAddress <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_startAccept) begin
                    r_index        <= '0;
                    r_mode         <= mode;
                    r_fill         <= fill_value;
                    r_verifyError  <= 1'b0;
                    r_errorAddress <= '0;
                end
            end else if (abort) begin
                r_index <= '0;
            end else if ((r_state == S_WRITE) || (r_state == S_READ)) begin
                r_index <= r_index + ONE_INDEX;
            end

            if (w_cmpValid && !abort && !r_verifyError &&
                (read_data_in != DATA_WIDTH'(w_cmpIndex))) begin
                r_verifyError  <= 1'b1;
                r_errorAddress <= ADDR_WIDTH'(w_cmpIndex);
            end
        end
    end

endmodule

// File: tb/tb_s_mem_init_engine.sv
// Testbench for s_mem_init_engine: directed table, random operations against
// a spec-level model, and hand sequences for abort, reset and ignored starts.
module tb_s_mem_init_engine;

    localparam int DEPTH = 256;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] fill_value;
    logic [7:0] address_out;
    logic [7:0] data_out;
    logic       write_enable_out;
    logic [7:0] read_data_in;
    logic       busy;
    logic       done;
    logic       verify_error;
    logic [7:0] error_address;

    logic       start_s;
    logic [3:0] address_s;
    logic [2:0] data_s;
    logic       we_s;
    logic [2:0] rd_s;
    logic       busy_s;
    logic       done_s;
    logic       verr_s;
    logic [3:0] eaddr_s;

    logic [7:0] mem [DEPTH];

    int passCnt;
    int totalCnt;

    typedef struct {
        int mode;
        int fill;
        bit mid;
        bit corrupt;
        int expErr;
        int expErrAddr;
    } vec_t;

    vec_t vecs [5];

    s_mem_init_engine dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .mode             (mode),
        .fill_value       (fill_value),
        .address_out      (address_out),
        .data_out         (data_out),
        .write_enable_out (write_enable_out),
        .read_data_in     (read_data_in),
        .busy             (busy),
        .done             (done),
        .verify_error     (verify_error),
        .error_address    (error_address)
    );

    s_mem_init_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(3), .DEPTH(16)) dutSmall (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start_s),
        .abort            (abort),
        .mode             (mode),
        .fill_value       (fill_value[2:0]),
        .address_out      (address_s),
        .data_out         (data_s),
        .write_enable_out (we_s),
        .read_data_in     (rd_s),
        .busy             (busy_s),
        .done             (done_s),
        .verify_error     (verr_s),
        .error_address    (eaddr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory model: read data returns one cycle after the address.
    always @(posedge clk) read_data_in <= mem[address_out];

    // Expected write word for index i from the mode rules.
    function automatic int expData(input int m, input int f, input int i,
                                   input int depth, input int dw);
        int modv;
        modv = 1 << dw;
        case (m)
            0:       return i % modv;
            1:       return f % modv;
            2:       return (depth - 1 - i) % modv;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalCnt++;
        if (actual == expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic fillIdentity();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    endtask

    // One full operation on the main instance, monitored cycle by cycle.
    task automatic applyStimulus(input string tag, input int m, input int f, input bit mid,
                                 input int expErr, input int expErrAddr);
        int nWr, nBad, doneCnt, doneOff, errAtDone, eaAtDone, busyStart, expA;
        int expWr, expDone;
        nWr = 0; nBad = 0; doneCnt = 0; doneOff = -1; errAtDone = -1; eaAtDone = -1;
        busyStart = 0;
        expWr   = (m == 3) ? 0 : DEPTH;
        expDone = (m == 3) ? DEPTH + 1 : DEPTH;
        @(negedge clk);
        mode = 2'(m); fill_value = 8'(f); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < DEPTH + 6; t++) begin
            if (t == 0) busyStart = int'(busy);
            if (write_enable_out) begin
                nWr++;
                if (m == 3 || t >= DEPTH || address_out != 8'(t) ||
                    data_out != 8'(expData(m, f, t, DEPTH, 8))) nBad++;
            end else begin
                if (m != 3 && t < DEPTH) nBad++;
                expA = (m == 3 && t < DEPTH) ? t : 0;
                if (address_out != 8'(expA) || data_out != 8'd0) nBad++;
            end
            if (done) begin
                doneCnt++; doneOff = t;
                errAtDone = int'(verify_error); eaAtDone = int'(error_address);
            end
            if (mid && t == 5) begin
                mode = 2'($urandom_range(0, 3)); fill_value = 8'($urandom); start = 1'b1;
            end
            if (mid && t == 6) start = 1'b0;
            @(negedge clk);
        end
        checkOutput({tag, "_busyStart"}, busyStart, 1);
        checkOutput({tag, "_writes"}, nWr, expWr);
        checkOutput({tag, "_badCycles"}, nBad, 0);
        checkOutput({tag, "_doneCount"}, doneCnt, 1);
        checkOutput({tag, "_doneCycle"}, doneOff, expDone);
        checkOutput({tag, "_verifyError"}, errAtDone, expErr);
        checkOutput({tag, "_errorAddress"}, eaAtDone, expErrAddr);
        checkOutput({tag, "_busyEnd"}, int'(busy), 0);
    endtask

    // One write operation on the narrow 16-word, 3-bit instance.
    task automatic runSmall(input string tag, input int m);
        int nWr, nBad, doneOff;
        nWr = 0; nBad = 0; doneOff = -1;
        @(negedge clk);
        mode = 2'(m); fill_value = 8'd0; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (we_s) begin
                nWr++;
                if (t >= 16 || address_s != 4'(t) || data_s != 3'(expData(m, 0, t, 16, 3))) nBad++;
            end
            if (done_s) doneOff = t;
            @(negedge clk);
        end
        checkOutput({tag, "_writes"}, nWr, 16);
        checkOutput({tag, "_badCycles"}, nBad, 0);
        checkOutput({tag, "_doneCycle"}, doneOff, 16);
    endtask

    // Abort while writing index 100: no further writes, no done, idle next cycle.
    task automatic abortSequence();
        int last, nAfter, doneSeen;
        last = -1; nAfter = 0; doneSeen = 0;
        @(negedge clk);
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t <= 100; t++) begin
            if (write_enable_out) last = int'(address_out);
            if (done) doneSeen++;
            if (t < 100) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busyNext", int'(busy), 0);
        for (int t = 0; t < 6; t++) begin
            if (write_enable_out) nAfter++;
            if (done) doneSeen++;
            @(negedge clk);
        end
        checkOutput("abort_lastIndexOk", int'(last == 99 || last == 100), 1);
        checkOutput("abort_writesAfter", nAfter, 0);
        checkOutput("abort_noDone", doneSeen, 0);
    endtask

    // Reset asserted while writing index 50: outputs clear without a clock edge.
    task automatic resetSequence();
        int sum, activeAfter;
        activeAfter = 0;
        @(negedge clk);
        mode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("rst_preAddress", int'(address_out), 50);
        #2 reset_n = 1'b0;
        #1;
        sum = int'(address_out) + int'(data_out) + int'(write_enable_out) + int'(busy) +
              int'(done) + int'(verify_error) + int'(error_address);
        checkOutput("rst_asyncOutputsZero", sum, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (busy || write_enable_out) activeAfter++;
            @(negedge clk);
        end
        checkOutput("rst_noResume", activeAfter, 0);
    endtask

    initial begin
        int m, f, n, a, expErr, expAddr;
        passCnt = 0; totalCnt = 0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; fill_value = 8'd0;
        start_s = 1'b0; rd_s = 3'd0;
        fillIdentity();

        vecs[0] = '{0, 0,     1'b0, 1'b0, 0, 0};
        vecs[1] = '{1, 8'hA5, 1'b1, 1'b0, 0, 0};
        vecs[2] = '{2, 0,     1'b0, 1'b0, 0, 0};
        vecs[3] = '{3, 0,     1'b1, 1'b0, 0, 0};
        vecs[4] = '{3, 0,     1'b0, 1'b1, 1, 8'h37};

        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_we", int'(write_enable_out), 0);
        checkOutput("reset_addrData", int'(address_out) + int'(data_out), 0);
        checkOutput("reset_doneErr", int'(done) + int'(verify_error) + int'(error_address), 0);
        start = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            fillIdentity();
            if (vecs[i].corrupt) begin
                mem[8'h37] = 8'h00;
                mem[8'h80] = 8'h00;
            end
            applyStimulus($sformatf("vec%0d", i), vecs[i].mode, vecs[i].fill, vecs[i].mid,
                          vecs[i].expErr, vecs[i].expErrAddr);
        end

        runSmall("small_mode2", 2);
        runSmall("small_mode0", 0);

        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(0, 3);
            f = $urandom_range(0, 255);
            fillIdentity();
            expErr = 0; expAddr = 0;
            if (m == 3) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    a = $urandom_range(0, DEPTH - 1);
                    mem[a] = 8'($urandom_range(0, 255));
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if (expErr == 0 && mem[k] != 8'(k)) begin
                        expErr = 1; expAddr = k;
                    end
                end
            end
            applyStimulus($sformatf("rand%0d_m%0d", r, m), m, f, 1'($urandom_range(0, 1)),
                          expErr, expAddr);
        end

        fillIdentity();
        abortSequence();
        applyStimulus("afterAbort", 0, 0, 1'b0, 0, 0);

        resetSequence();
        applyStimulus("afterReset", 2, 0, 1'b0, 0, 0);

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n = 0;
        for (int t = 0; t < 4; t++) begin
            if (busy) n++;
            @(negedge clk);
        end
        checkOutput("idleAbort_blocksStart", n, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
